// File: rtl/spi_pkg.sv
// Shared SPI frame definitions.
// Frame layout (MSB first on the wire): [15] R/W (1 = read), [14:8] address,
// [7:0] data. The SPI master uses the same constants, so change them together.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int RW_BIT  = 15;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  // Responder frame state, also exported on the debug output o_state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI line plus a third stage used
// to detect edges of the synchronised level.
// Ports:
//   i_clock  system clock
//   i_reset  synchronous active-high reset (all stages load IDLE_LEVEL)
//   i_async  asynchronous input line
//   o_rise   one-cycle pulse on a synchronised 0->1 transition
//   o_fall   one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] stage;
  logic [1:0] warm_cnt;
  logic       primed;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stage    <= {3{IDLE_LEVEL}};
      warm_cnt <= 2'd0;
    end else begin
      stage <= {stage[1:0], i_async};
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  // Edges are suppressed until every stage holds a real sample. Without this,
  // leaving reset while the line sits at its non-idle level (CS held low
  // mid-frame) would look like an edge against the reset value.
  assign primed = (warm_cnt == 2'd3);
  assign o_rise = primed &  stage[1] & ~stage[2];
  assign o_fall = primed & ~stage[1] &  stage[2];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 slave emulating the Bluejay SLM control-register interface.
// SCLK/CS/MOSI are oversampled in the i_clock domain; fixed 16-bit frames
// write or read a small register file plus a read-only identity register.
// Ports:
//   i_clock, i_reset      system clock, synchronous active-high reset
//   i_sclk, i_cs_n, i_mosi asynchronous SPI inputs from the master
//   o_miso                read data, MSB first, changes on SCLK fall
//   o_wr_valid            one-cycle strobe for an accepted write
//   o_wr_addr, o_wr_data  address/data of the last accepted write (held)
//   o_frame_error         one-cycle pulse when CS rises mid-frame
//   o_busy                high while a frame window is open
//   o_state               frame state, for debug/monitoring
// o_wr_valid is a strobe with no ready: it is high for exactly one cycle per
// accepted write, o_wr_addr/o_wr_data are valid in that cycle and held after.
module spi_responder
  import spi_pkg::*;
#(
  parameter int                NUM_REGS     = 16,
  parameter logic [ADDR_W-1:0] WHOAMI_ADDR  = 7'h78,
  parameter logic [DATA_W-1:0] WHOAMI_VALUE = 8'hA5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_frame_error,
  output logic              o_busy,
  output spi_state_t        o_state
);

  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_ff;
  logic       mosi_s;

  spi_state_t          state, state_next;
  logic [4:0]          bit_cnt;
  logic [FRAME_W-1:0]  rx_sr, frame_next;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                shift_en, last_bit, frame_err, wr_ok;

  spi_sync_edge #(.IDLE_LEVEL(1'b0)) u_sclk_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_sclk),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall)
  );

  spi_sync_edge #(.IDLE_LEVEL(1'b1)) u_cs_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_cs_n),
    .o_rise  (cs_rise),
    .o_fall  (cs_fall)
  );

  // MOSI needs the same two-stage depth as SCLK so the sampled bit lines up
  // with the detected rising edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) mosi_ff <= 2'b00;
    else         mosi_ff <= {mosi_ff[0], i_mosi};
  end
  assign mosi_s = mosi_ff[1];

  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] addr);
    if (addr < NUM_REGS_A)        return regs[addr[IDX_W-1:0]];
    else if (addr == WHOAMI_ADDR) return WHOAMI_VALUE;
    else                          return '0;
  endfunction

  // Frame contents including the bit being shifted in this cycle.
  assign frame_next = {rx_sr[FRAME_W-2:0], mosi_s};
  assign wr_ok = last_bit && !frame_next[RW_BIT]
                 && (frame_next[14:8] < NUM_REGS_A);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    last_bit   = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          frame_err  = (bit_cnt != 5'd0);
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd15) begin
            last_bit   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Extra SCLK edges are ignored; only CS rising ends the frame.
        if (cs_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      o_miso        <= 1'b0;
      o_wr_valid    <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_frame_error <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      o_wr_valid    <= wr_ok;
      o_frame_error <= frame_err;

      if (state == ST_IDLE) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
      end

      if (shift_en) begin
        rx_sr   <= frame_next;
        bit_cnt <= bit_cnt + 5'd1;
        // Header complete after the 8th bit: capture read data now so it is
        // ready for the 8th falling edge.
        if (bit_cnt == 5'd7)
          tx_sr <= frame_next[7] ? read_mux(frame_next[ADDR_W-1:0]) : '0;
      end

      if (wr_ok) begin
        regs[frame_next[8+IDX_W-1:8]] <= frame_next[DATA_W-1:0];
        o_wr_addr                     <= frame_next[14:8];
        o_wr_data                     <= frame_next[DATA_W-1:0];
      end

      // MISO moves only on SCLK fall; bit_cnt here equals the fall number.
      if (state != ST_SHIFT) begin
        o_miso <= 1'b0;
      end else if (sclk_fall) begin
        if (bit_cnt == 5'd8) begin
          o_miso <= tx_sr[7];
        end else if (bit_cnt > 5'd8) begin
          o_miso <= tx_sr[6];
          tx_sr  <= tx_sr << 1;
        end else begin
          o_miso <= 1'b0;
        end
      end
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_spi_responder.sv
module tb_spi_responder;
  import spi_pkg::*;

  localparam int          NUM_REGS = 16;
  localparam logic [6:0]  WHO_ADDR = 7'h78;
  localparam logic [7:0]  WHO_VAL  = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, sclk, cs_n, mosi;
  logic miso, wr_valid, frame_error, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  spi_state_t state;

  always #5 clk = ~clk;

  spi_responder #(
    .NUM_REGS     (NUM_REGS),
    .WHOAMI_ADDR  (WHO_ADDR),
    .WHOAMI_VALUE (WHO_VAL)
  ) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_sclk        (sclk),
    .i_cs_n        (cs_n),
    .i_mosi        (mosi),
    .o_miso        (miso),
    .o_wr_valid    (wr_valid),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_frame_error (frame_error),
    .o_busy        (busy),
    .o_state       (state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] model_regs [NUM_REGS];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int half     = 4;

  // Pulse monitor: counts high samples so a stretched pulse counts as two.
  int wr_cnt  = 0;
  int err_cnt = 0;
  logic [6:0] mon_addr = '0;
  logic [7:0] mon_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_valid) begin
        wr_cnt++;
        mon_addr = wr_addr;
        mon_data = wr_data;
      end
      if (frame_error) err_cnt++;
    end
  end

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (int'(a) < NUM_REGS) return model_regs[a[3:0]];
    if (a == WHO_ADDR)      return WHO_VAL;
    return 8'h00;
  endfunction

  function automatic logic model_writes(input logic [6:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: MOSI changes while SCLK is low, MISO is sampled just
  // before each rising edge. rx collects the bits seen before rises 9..16.
  task automatic xfer(input logic [15:0] frame, input int nbits, input int extra_rises,
                      output logic [7:0] rx, output logic busy_mid);
    rx = '0;
    busy_mid = 1'b0;
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[15-i];
      repeat (half) @(negedge clk);
      if (i >= 8) rx[15-i] = miso;
      if (i == 4) busy_mid = busy;
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    for (int i = 0; i < extra_rises; i++) begin
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    idle(4);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b want 0", miso); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid); end
    n_checks++; if (wr_addr !== 7'h00) begin n_fail++; $display("FAIL rst_wr_addr: got %h want 00", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL rst_frame_error: got %b want 0", frame_error); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state, ST_IDLE); end
    reset = 1'b0;
    idle(6);
  endtask

  task automatic test_write_read;
    logic [7:0] rx; logic b; int w0;
    w0 = wr_cnt;
    xfer({1'b0, 7'h09, 8'h32}, 16, 0, rx, b);
    idle(6);
    model_regs[9] = 8'h32;
    n_checks++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL wr_pulse_count: got %0d want 1", wr_cnt - w0); end
    n_checks++; if (mon_addr !== 7'h09) begin n_fail++; $display("FAIL wr_pulse_addr: got %h want 09", mon_addr); end
    n_checks++; if (mon_data !== 8'h32) begin n_fail++; $display("FAIL wr_pulse_data: got %h want 32", mon_data); end
    n_checks++; if (wr_addr !== 7'h09 || wr_data !== 8'h32) begin n_fail++; $display("FAIL wr_hold: got %h/%h want 09/32", wr_addr, wr_data); end
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL busy_mid_frame: got %b want 1", b); end
    n_checks++; if (rx !== 8'h00) begin n_fail++; $display("FAIL write_frame_miso: got %h want 00", rx); end
    w0 = wr_cnt;
    xfer({1'b1, 7'h09, 8'h00}, 16, 0, rx, b);
    idle(6);
    n_checks++; if (rx !== model_read(7'h09)) begin n_fail++; $display("FAIL read_back_09: got %h want %h", rx, model_read(7'h09)); end
    n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL read_no_wr_pulse: got %0d want 0", wr_cnt - w0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b want 0", busy); end
  endtask

  task automatic test_identity;
    logic [7:0] rx; logic b; int w0;
    xfer(16'hF800, 16, 0, rx, b);
    idle(6);
    n_checks++; if (rx !== WHO_VAL) begin n_fail++; $display("FAIL whoami_read: got %h want %h", rx, WHO_VAL); end
    w0 = wr_cnt;
    xfer(16'h7811, 16, 0, rx, b);
    idle(6);
    n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL whoami_write_pulse: got %0d want 0", wr_cnt - w0); end
    xfer(16'hF800, 16, 0, rx, b);
    idle(6);
    n_checks++; if (rx !== WHO_VAL) begin n_fail++; $display("FAIL whoami_reread: got %h want %h", rx, WHO_VAL); end
  endtask

  task automatic test_out_of_range;
    logic [7:0] rx; logic b; int w0;
    w0 = wr_cnt;
    xfer(16'h20FF, 16, 0, rx, b);
    idle(6);
    n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL oor_write_pulse: got %0d want 0", wr_cnt - w0); end
    xfer(16'hA000, 16, 0, rx, b);
    idle(6);
    n_checks++; if (rx !== 8'h00) begin n_fail++; $display("FAIL oor_read: got %h want 00", rx); end
    // Highest implemented address still behaves as a normal register.
    xfer({1'b0, 7'(NUM_REGS - 1), 8'h6C}, 16, 0, rx, b);
    idle(6);
    model_regs[NUM_REGS-1] = 8'h6C;
    xfer({1'b1, 7'(NUM_REGS - 1), 8'h00}, 16, 0, rx, b);
    idle(6);
    n_checks++; if (rx !== 8'h6C) begin n_fail++; $display("FAIL top_reg_read: got %h want 6c", rx); end
  endtask

  task automatic test_abort;
    logic [7:0] rx, d; logic b; int w0, e0;
    d = 8'($urandom);
    w0 = wr_cnt; e0 = err_cnt;
    xfer({1'b0, 7'h03, d}, 10, 0, rx, b);
    idle(6);
    n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL abort_error_pulse: got %0d want 1", err_cnt - e0); end
    n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL abort_no_write: got %0d want 0", wr_cnt - w0); end
    xfer({1'b1, 7'h03, 8'h00}, 16, 0, rx, b);
    idle(6);
    n_checks++; if (rx !== model_read(7'h03)) begin n_fail++; $display("FAIL abort_reg_unchanged: got %h want %h", rx, model_read(7'h03)); end
    w0 = wr_cnt; e0 = err_cnt;
    xfer({1'b0, 7'h03, d}, 16, 0, rx, b);
    idle(6);
    model_regs[3] = d;
    n_checks++; if (wr_cnt - w0 != 1 || mon_data !== d) begin n_fail++; $display("FAIL after_abort_write: got %0d/%h want 1/%h", wr_cnt - w0, mon_data, d); end
    n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL full_frame_no_error: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] rx; logic b; int w0, e0; logic [15:0] fr;
    xfer({1'b0, 7'h01, 8'h5A}, 16, 0, rx, b);
    idle(6);
    model_regs[1] = 8'h5A;
    w0 = wr_cnt; e0 = err_cnt;
    fr = {1'b0, 7'h01, 8'($urandom)};
    cs_n = 1'b0;
    idle(half);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        reset = 1'b1;
        idle(3);
        n_checks++; if ({miso, wr_valid, frame_error, busy} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags: got %b want 0000", {miso, wr_valid, frame_error, busy}); end
        n_checks++; if (wr_addr !== 7'h00 || wr_data !== 8'h00) begin n_fail++; $display("FAIL midrst_wr_regs: got %h/%h want 00/00", wr_addr, wr_data); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", state, ST_IDLE); end
        reset = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
      end
      mosi = fr[15-i];
      idle(half);
      sclk = 1'b1;
      idle(half);
      sclk = 1'b0;
    end
    idle(half);
    cs_n = 1'b1;
    idle(8);
    n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL midrst_no_write: got %0d want 0", wr_cnt - w0); end
    n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL midrst_no_error: got %0d want 0", err_cnt - e0); end
    xfer({1'b1, 7'h01, 8'h00}, 16, 0, rx, b);
    idle(6);
    n_checks++; if (rx !== model_read(7'h01)) begin n_fail++; $display("FAIL midrst_reg_cleared: got %h want %h", rx, model_read(7'h01)); end
  endtask

  task automatic test_random;
    logic [7:0] rx, d, exp; logic b, rw; logic [6:0] a; int w0, e0, sel;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 7'($urandom_range(0, NUM_REGS - 1));
      else if (sel < 8) a = WHO_ADDR;
      else              a = 7'($urandom);
      rw   = 1'($urandom);
      d    = 8'($urandom);
      half = $urandom_range(4, 6);
      if (rw) exp_q.push_back(model_read(a));
      w0 = wr_cnt; e0 = err_cnt;
      xfer({rw, a, d}, 16, 0, rx, b);
      idle($urandom_range(3, 8));
      if (rw) begin
        exp = exp_q.pop_front();
        n_checks++; if (rx !== exp) begin n_fail++; $display("FAIL rand_read a=%h: got %h want %h", a, rx, exp); end
        n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL rand_read_pulse a=%h: got %0d want 0", a, wr_cnt - w0); end
      end else if (model_writes(a)) begin
        model_regs[a[3:0]] = d;
        n_checks++; if (wr_cnt - w0 != 1 || mon_addr !== a || mon_data !== d) begin
          n_fail++; $display("FAIL rand_write: got %0d %h/%h want 1 %h/%h", wr_cnt - w0, mon_addr, mon_data, a, d);
        end
      end else begin
        n_checks++; if (wr_cnt != w0) begin n_fail++; $display("FAIL rand_ignored_write a=%h: got %0d want 0", a, wr_cnt - w0); end
      end
      n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL rand_error a=%h: got %0d want 0", a, err_cnt - e0); end
    end
    half = 4;
  endtask

  task automatic test_back_to_back;
    logic [7:0] rx1, rx2, d; logic b; logic [6:0] a; int w0, e0;
    half = 4;
    a = 7'($urandom_range(0, NUM_REGS - 1));
    d = 8'($urandom);
    w0 = wr_cnt; e0 = err_cnt;
    // Write with a 17th SCLK edge, CS high for exactly 2 cycles, then read.
    xfer({1'b0, a, d}, 16, 1, rx1, b);
    idle(2);
    model_regs[a[3:0]] = d;
    xfer({1'b1, a, 8'h00}, 16, 0, rx2, b);
    idle(2);
    // Read of the identity register, back-to-back again.
    xfer({1'b1, WHO_ADDR, 8'h00}, 16, 1, rx1, b);
    idle(8);
    n_checks++; if (wr_cnt - w0 != 1 || mon_data !== d) begin n_fail++; $display("FAIL b2b_write: got %0d/%h want 1/%h", wr_cnt - w0, mon_data, d); end
    n_checks++; if (rx2 !== model_read(a)) begin n_fail++; $display("FAIL b2b_read: got %h want %h", rx2, model_read(a)); end
    n_checks++; if (rx1 !== WHO_VAL) begin n_fail++; $display("FAIL b2b_whoami: got %h want %h", rx1, WHO_VAL); end
    n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL b2b_no_error: got %0d want 0", err_cnt - e0); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset;
    test_write_read;
    test_identity;
    test_out_of_range;
    test_abort;
    test_reset_mid_frame;
    test_random;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI slave that emulates the Bluejay SLM control-register interface.
- Lets the on-board SPI master, the UART command path and the bench be exercised without the SLM, via a loopback strap or test header.
- Oversamples SCLK/CS/MOSI in the i_clock domain, decodes fixed 16-bit frames (R/W + 7-bit address + 8-bit data), holds a small register file and returns read data on MISO.
- Write strobes are exported so application logic can react to writes.

Parameters:
- NUM_REGS, 16: number of implemented read/write registers at addresses 0..NUM_REGS-1 (max 64).
- WHOAMI_ADDR, 7'h78: address of the read-only identity register.
- WHOAMI_VALUE, 8'hA5: value returned when WHOAMI_ADDR is read.

Ports:
- i_clock  in  1  system clock (50 MHz)
- i_reset  in  1  synchronous active-high reset
- i_sclk  in  1  SPI clock from master, asynchronous, idle low (mode 0)
- i_cs_n  in  1  chip select, active low, asynchronous
- i_mosi  in  1  serial data from master, MSB first
- o_miso  out  1  serial data to master, MSB first
- o_wr_valid  out  1  one-cycle pulse on a completed write frame
- o_wr_addr  out  7  address of last write
- o_wr_data  out  8  data of last write
- o_frame_error  out  1  one-cycle pulse when CS rises with bit count not 0 and not 16
- o_busy  out  1  high while CS is asserted (synchronised)

Behaviour:
- Input sync: 2-FF synchroniser on i_sclk, i_cs_n and i_mosi, plus a third stage on i_sclk/i_cs_n for edge detect.
  - Edge-to-action latency is 3 i_clock cycles.
  - Requires SCLK high and low phases of at least 4 i_clock cycles each.
- Frame format: bit15 = R/W (1 = read), bits14:8 = addr, bits7:0 = data.
- State machine:
  - IDLE: CS synchronously high; bit_cnt = 0. Go to SHIFT on CS fall.
  - SHIFT: on each SCLK rise, shift MOSI into rx_sr[15:0] and increment bit_cnt (5-bit).
    - After rise #8: if read, load tx_sr <= read_mux(addr).
    - After rise #16: go to DONE.
  - DONE: if write and addr is a valid RW register, write regs[addr] and pulse o_wr_valid in the same cycle. Further SCLK rises are ignored until CS rises. Return to IDLE on CS rise.
  - CS rise from SHIFT (any state other than IDLE/DONE): pulse o_frame_error, discard the frame with no write, go to IDLE.
- MISO: updates only on synchronised SCLK fall.
  - Falls 1..7: drive 0.
  - Fall 8: drive tx_sr[7].
  - Falls 9..15: shift left, drive next bit.
  - Write frames: drive 0 throughout.
  - When CS is high: drive 0.
- read_mux(addr):
  - addr < NUM_REGS: regs[addr].
  - addr == WHOAMI_ADDR: WHOAMI_VALUE.
  - Otherwise: 8'h00.
- Writes to WHOAMI_ADDR or to addresses ≥ NUM_REGS are ignored: no regs change and no o_wr_valid pulse.
- CS falls again in the same cycle DONE exits: IDLE entry is mandatory. The new frame starts on the next detected CS fall, and back-to-back frames need ≥ 2 i_clock cycles of CS high.
- Reset (any time, including mid-frame):
  - regs all 8'h00; state IDLE; bit_cnt, rx_sr, tx_sr = 0.
  - o_miso = 0, o_wr_valid = 0, o_wr_addr = 0, o_wr_data = 0, o_frame_error = 0, o_busy = 0.
  - Synchroniser flops reset to idle levels: sclk 0, cs_n 1, mosi 0.
  - After reset releases mid-frame with CS still low, the block stays in IDLE until CS rises and falls again; no spurious frame_error.
- o_wr_addr/o_wr_data: update only on valid writes and hold otherwise.

Decomposition:
- Shared package spi_pkg: frame width 16, RW bit index 15, address width 7, data width 8, and state encoding (IDLE, SHIFT, DONE). The existing SPI master shares the frame constants.
- One natural sub-module: spi_sync_edge. It contains the 2-FF synchroniser and the rise/fall detector, and is instantiated for SCLK and CS (MOSI uses sync only).

Test Plan:
- Write then read: write frame 0x09/0x32, then read frame 0x89/0x00 → o_wr_valid pulse with addr 0x09, data 0x32; MISO bits 7..0 on the second frame = 0x32.
- Identity: read frame 0xF8/0x00 → MISO returns 0xA5. Write frame 0x78/0x11 → no o_wr_valid; a subsequent read still returns 0xA5.
- Out-of-range: write 0x20/0xFF, then read 0xA0 → no write pulse; returns 0x00.
- Aborted frame: CS low, 10 SCLK cycles, CS high → one-cycle o_frame_error; regs unchanged; next full frame decodes correctly.
- Reset mid-frame: assert i_reset after 5 bits of a write to 0x01 → all outputs 0; reg 0x01 reads 0x00; the remaining bits in that CS window are ignored.
- Timing margin: back-to-back frames with 2-cycle CS gap at SCLK = i_clock/8 → both frames decode; 17th SCLK edge in one frame ignored, no error.
